// File: rtl/systolic_skew_feeder_if.sv
`default_nettype none
// ============================================================================
// systolic_skew_feeder_if: operand/handshake bundle between buffers and feeder.
// Rev 1.0
// ============================================================================
interface systolic_skew_feeder_if #(
  parameter int N     = 32,
  parameter int SIZE  = 4,
  parameter int K_MAX = 64
);
  logic                         start;
  logic [$clog2(K_MAX+1)-1:0]   k_len;
  logic [SIZE*N-1:0]            a_in;
  logic [SIZE*N-1:0]            b_in;
  logic                         in_valid;
  logic                         in_ready;
  logic [SIZE*N-1:0]            x_edge;
  logic [SIZE*N-1:0]            y_edge;
  logic                         arr_en;
  logic                         acc_clr;
  logic                         busy;
  logic                         done;

  modport master (
    output start, k_len, a_in, b_in, in_valid,
    input  in_ready, x_edge, y_edge, arr_en, acc_clr, busy, done
  );

  modport slave (
    input  start, k_len, a_in, b_in, in_valid,
    output in_ready, x_edge, y_edge, arr_en, acc_clr, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
// systolic_skew_feeder: diagonal-skew west/north edge feeder for the PE array.
// Option SKEW_FEEDER_BUBBLE_EN: input bubbles still advance with zeros. Rev 1.0
// ============================================================================
module systolic_skew_feeder #(
  parameter int N       = 32,
  parameter int SIZE    = 4,
  parameter int K_MAX   = 64,
  parameter int MAC_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  systolic_skew_feeder_if.slave bus
);
  localparam int KW        = $clog2(K_MAX + 1);
  localparam int DRAIN_LEN = 2 * (SIZE - 1) + MAC_LAT;
  localparam int DW        = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_len_q, k_len_d;
  logic [KW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [DW-1:0]   drain_cnt_q, drain_cnt_d;

  logic feeding, draining, accept, advance, inject_zero, skew_clr;
  logic [SIZE*N-1:0] x_edge_w, y_edge_w;

  assign feeding  = (state_q == S_FEED);
  assign draining = (state_q == S_DRAIN);
  assign accept   = feeding & bus.in_valid;
  assign skew_clr = (state_q == S_IDLE) & bus.start;

`ifdef SKEW_FEEDER_BUBBLE_EN
  assign advance     = feeding | draining;
  assign inject_zero = draining | (feeding & ~bus.in_valid);
`else
  assign advance     = accept | draining;
  assign inject_zero = draining;
`endif

  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    beat_cnt_d  = beat_cnt_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d     = S_CLEAR;
          k_len_d     = bus.k_len;
          beat_cnt_d  = '0;
          drain_cnt_d = '0;
        end
      end
      S_CLEAR: state_d = (k_len_q == '0) ? S_DONE : S_FEED;
      S_FEED: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_d == k_len_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        drain_cnt_d = drain_cnt_q + 1'b1;
        if (drain_cnt_q == DW'(DRAIN_LEN - 1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_len_q     <= '0;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      beat_cnt_q  <= beat_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    logic [N-1:0] x_inj, y_inj;
    assign x_inj = inject_zero ? '0 : bus.a_in[i*N +: N];
    assign y_inj = inject_zero ? '0 : bus.b_in[i*N +: N];

    if (i == 0) begin : g_pass
      // Lane 0 is transparent on an advance and replays the last advanced value otherwise.
      logic [N-1:0] x_hold_q, x_hold_d, y_hold_q, y_hold_d;
      always_comb begin
        x_hold_d = x_hold_q;
        y_hold_d = y_hold_q;
        if (skew_clr) begin
          x_hold_d = '0;
          y_hold_d = '0;
        end else if (advance) begin
          x_hold_d = x_inj;
          y_hold_d = y_inj;
        end
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          x_hold_q <= '0;
          y_hold_q <= '0;
        end else begin
          x_hold_q <= x_hold_d;
          y_hold_q <= y_hold_d;
        end
      end
      assign x_edge_w[i*N +: N] = advance ? x_inj : x_hold_q;
      assign y_edge_w[i*N +: N] = advance ? y_inj : y_hold_q;
    end else begin : g_shift
      logic [N-1:0] x_sr_q [i];
      logic [N-1:0] x_sr_d [i];
      logic [N-1:0] y_sr_q [i];
      logic [N-1:0] y_sr_d [i];
      always_comb begin
        x_sr_d = x_sr_q;
        y_sr_d = y_sr_q;
        if (skew_clr) begin
          x_sr_d = '{default: '0};
          y_sr_d = '{default: '0};
        end else if (advance) begin
          x_sr_d[0] = x_inj;
          y_sr_d[0] = y_inj;
          for (int s = 1; s < i; s++) begin
            x_sr_d[s] = x_sr_q[s-1];
            y_sr_d[s] = y_sr_q[s-1];
          end
        end
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          x_sr_q <= '{default: '0};
          y_sr_q <= '{default: '0};
        end else begin
          x_sr_q <= x_sr_d;
          y_sr_q <= y_sr_d;
        end
      end
      assign x_edge_w[i*N +: N] = x_sr_q[i-1];
      assign y_edge_w[i*N +: N] = y_sr_q[i-1];
    end
  end

  assign bus.x_edge   = x_edge_w;
  assign bus.y_edge   = y_edge_w;
  assign bus.in_ready = feeding;
  assign bus.arr_en   = advance;
  assign bus.acc_clr  = (state_q == S_CLEAR);
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
endmodule
`default_nettype wire
